// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game state, direction latch, level/speed select and BCD score.
// Optional score-driven speed-up is enabled by defining SNAKE_SCORE_SPEEDUP_EN.
module snake_game_ctrl #(
  parameter logic [27:0] SPEED_L1   = 28'd25_000_000,
  parameter logic [27:0] SPEED_L2   = 28'd12_500_000,
  parameter logic [27:0] SPEED_L3   = 28'd6_250_000,
  parameter logic [6:0]  WIN_SCORE  = 7'd20,
`ifdef SNAKE_SCORE_SPEEDUP_EN
  parameter logic [27:0] SPEED_STEP = 28'd1_000_000,
  parameter logic [27:0] SPEED_MIN  = 28'd2_000_000,
`endif
  parameter logic [27:0] OVER_HOLD  = 28'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        key_pause,
  input  logic [2:0]  key_level,
  input  logic [3:0]  key_dir,
  input  logic        target_ate,
  input  logic        lost,
  output logic [2:0]  game_state,
  output logic [1:0]  dir_state,
  output logic [27:0] mov_speed,
  output logic [3:0]  score_count0,
  output logic [3:0]  score_count1,
  output logic [1:0]  level
);

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_CHOOSE = 3'd1;
  localparam logic [2:0] ST_IDLE = 3'd2;
  localparam logic [2:0] ST_PLAY = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [2:0] ST_WIN = 3'd5;
  localparam logic [2:0] ST_OVER = 3'd6;

  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [2:0]  r_state, w_state_next;
  logic [1:0]  r_dir, w_dir_next;
  logic [1:0]  r_level, w_level_next;
  logic [27:0] r_speed, w_speed_next;
  logic [3:0]  r_units, w_units_next;
  logic [3:0]  r_tens, w_tens_next;
  logic [27:0] r_hold, w_hold_next;
  logic        r_ate_d;

  logic        w_ate_edge;
  logic        w_score_sat;
  logic [6:0]  w_score_bin;
  logic        w_inc;
  logic        w_wrap;
  logic [1:0]  w_dir_req;
  logic        w_dir_accept;

  assign w_ate_edge  = target_ate & ~r_ate_d;
  assign w_score_sat = (r_tens == 4'd9) && (r_units == 4'd9);
  assign w_score_bin = ({3'b000, r_tens} * 7'd10) + {3'b000, r_units};
  assign w_inc       = (r_state == ST_PLAY) && w_ate_edge && !w_score_sat;
  assign w_wrap      = w_inc && (r_units == 4'd9);

  // key_dir bit index equals the dir_state encoding; lowest bit has priority
  always_comb begin
    w_dir_req = DIR_RIGHT;
    if (key_dir[0])      w_dir_req = 2'd0;
    else if (key_dir[1]) w_dir_req = 2'd1;
    else if (key_dir[2]) w_dir_req = 2'd2;
  end

  assign w_dir_accept = (r_state == ST_PLAY) && (|key_dir) &&
                        (w_dir_req != (r_dir ^ 2'b10));

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_speed_next = r_speed;
    w_hold_next  = '0;
    w_dir_next   = r_dir;
    w_units_next = r_units;
    w_tens_next  = r_tens;

    case (r_state)
      ST_START: begin
        if (key_start) w_state_next = ST_CHOOSE;
      end
      ST_CHOOSE: begin
        if (|key_level) begin
          w_state_next = ST_IDLE;
          w_dir_next   = DIR_RIGHT;
          w_units_next = '0;
          w_tens_next  = '0;
          if (key_level[0]) begin
            w_level_next = 2'd1;
            w_speed_next = SPEED_L1;
          end else if (key_level[1]) begin
            w_level_next = 2'd2;
            w_speed_next = SPEED_L2;
          end else begin
            w_level_next = 2'd3;
            w_speed_next = SPEED_L3;
          end
        end
      end
      ST_IDLE: begin
        w_dir_next   = DIR_RIGHT;
        w_units_next = '0;
        w_tens_next  = '0;
        if (key_start) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (lost)                            w_state_next = ST_OVER;
        else if (w_score_bin >= WIN_SCORE)   w_state_next = ST_WIN;
        else if (key_pause)                  w_state_next = ST_PAUSE;
        if (w_dir_accept) w_dir_next = w_dir_req;
        if (w_inc) begin
          if (w_wrap) begin
            w_units_next = '0;
            w_tens_next  = r_tens + 4'd1;
          end else begin
            w_units_next = r_units + 4'd1;
          end
        end
`ifdef SNAKE_SCORE_SPEEDUP_EN
        // compare first so the subtract can never undershoot the floor
        if (w_wrap) begin
          if (r_speed >= SPEED_MIN + SPEED_STEP) w_speed_next = r_speed - SPEED_STEP;
          else                                   w_speed_next = SPEED_MIN;
        end
`endif
      end
      ST_PAUSE: begin
        if (key_pause) w_state_next = ST_PLAY;
      end
      ST_WIN: begin
        if (key_start) w_state_next = ST_START;
      end
      ST_OVER: begin
        if (key_start || (r_hold == OVER_HOLD - 28'd1)) w_state_next = ST_START;
        else w_hold_next = r_hold + 28'd1;
      end
      default: w_state_next = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_START;
      r_dir   <= DIR_RIGHT;
      r_level <= 2'd1;
      r_speed <= SPEED_L1;
      r_units <= '0;
      r_tens  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_dir   <= w_dir_next;
      r_level <= w_level_next;
      r_speed <= w_speed_next;
      r_units <= w_units_next;
      r_tens  <= w_tens_next;
      r_hold  <= w_hold_next;
    end
  end

  // edge detector tracks the input continuously, including through reset
  always_ff @(posedge clk) begin
    r_ate_d <= target_ate;
  end

  assign game_state   = r_state;
  assign dir_state    = r_dir;
  assign mov_speed    = r_speed;
  assign score_count0 = r_units;
  assign score_count1 = r_tens;
  assign level        = r_level;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios then random stimulus vs a score/state model.
module tb_snake_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_start = 1'b0;
  logic        key_pause = 1'b0;
  logic [2:0]  key_level = '0;
  logic [3:0]  key_dir = '0;
  logic        target_ate = 1'b0;
  logic        lost = 1'b0;
  logic [2:0]  game_state;
  logic [1:0]  dir_state;
  logic [27:0] mov_speed;
  logic [3:0]  score_count0;
  logic [3:0]  score_count1;
  logic [1:0]  level;

  int n_tests = 0;
  int n_fail  = 0;

  // model: score held as a plain integer 0..99
  int m_state = 0, m_dir = 3, m_level = 1, m_speed = 25_000_000;
  int m_score = 0, m_hold = 0, m_prev = 0;
  int speed_tab [1:3] = '{25_000_000, 12_500_000, 6_250_000};
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  snake_game_ctrl #(.OVER_HOLD(28'd8)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_pause(key_pause),
    .key_level(key_level), .key_dir(key_dir), .target_ate(target_ate), .lost(lost),
    .game_state(game_state), .dir_state(dir_state), .mov_speed(mov_speed),
    .score_count0(score_count0), .score_count1(score_count1), .level(level)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rs, st, pa, input bit [2:0] lv, input bit [3:0] kd,
                            input bit at, lo);
    int n_state = m_state, n_dir = m_dir, n_level = m_level, n_speed = m_speed;
    int n_score = m_score, n_hold = 0, cand;
    bit edge_seen = at && (m_prev == 0);
    if (!rs) begin
      n_state = 0; n_dir = 3; n_level = 1; n_speed = speed_tab[1]; n_score = 0;
    end else begin
      case (m_state)
        0: if (st) n_state = 1;
        1: if (lv != 0) begin
             n_level = lv[0] ? 1 : (lv[1] ? 2 : 3);
             n_speed = speed_tab[n_level];
             n_state = 2; n_score = 0; n_dir = 3;
           end
        2: begin n_dir = 3; n_score = 0; if (st) n_state = 3; end
        3: begin
             if (edge_seen && m_score < 99) begin
               n_score = m_score + 1;
`ifdef SNAKE_SCORE_SPEEDUP_EN
               if (m_score % 10 == 9)
                 n_speed = (m_speed - 1_000_000 >= 2_000_000) ? m_speed - 1_000_000 : 2_000_000;
`endif
             end
             if (kd != 0) begin
               cand = kd[0] ? 0 : (kd[1] ? 1 : (kd[2] ? 2 : 3));
               if (cand != (m_dir + 2) % 4) n_dir = cand;
             end
             if (lo) n_state = 6;
             else if (m_score >= 20) n_state = 5;
             else if (pa) n_state = 4;
           end
        4: if (pa) n_state = 3;
        5: if (st) n_state = 0;
        6: if (st || m_hold == 7) n_state = 0; else n_hold = m_hold + 1;
        default: n_state = 0;
      endcase
    end
    m_state = n_state; m_dir = n_dir; m_level = n_level; m_speed = n_speed;
    m_score = n_score; m_hold = n_hold; m_prev = at;
  endtask

  task automatic tick(input bit rs, st, pa, input bit [2:0] lv, input bit [3:0] kd,
                      input bit at, lo);
    int old_state = m_state;
    rst = rs; key_start = st; key_pause = pa; key_level = lv;
    key_dir = kd; target_ate = at; lost = lo;
    model_step(rs, st, pa, lv, kd, at, lo);
    @(posedge clk);
    #1;
    check_val("state", 32'(game_state), m_state);
    check_val("dir", 32'(dir_state), m_dir);
    check_val("level", 32'(level), m_level);
    check_val("speed", 32'(mov_speed), m_speed);
    check_val("units", 32'(score_count0), m_score % 10);
    check_val("tens", 32'(score_count1), m_score / 10);
    if (verbose || old_state != m_state)
      $display("[TB] t=%0t rst=%0b st=%0b pa=%0b lv=%b kd=%b ate=%0b lost=%0b -> state=%0d dir=%0d lvl=%0d spd=%0d score=%0d%0d",
               $time, rs, st, pa, lv, kd, at, lo, game_state, dir_state, level,
               mov_speed, score_count1, score_count0);
  endtask

  task automatic eat_pulse();
    tick(1, 0, 0, 3'b000, 4'b0000, 1, 0);
    tick(1, 0, 0, 3'b000, 4'b0000, 1, 0);
    tick(1, 0, 0, 3'b000, 4'b0000, 0, 0);
  endtask

  initial begin
    // reset
    tick(0, 0, 0, 3'b000, 4'b0000, 0, 0);
    tick(0, 0, 0, 3'b000, 4'b0000, 0, 0);
    check_val("rst_state", 32'(game_state), 0);
    check_val("rst_dir", 32'(dir_state), 3);
    check_val("rst_level", 32'(level), 1);
    check_val("rst_speed", 32'(mov_speed), 25_000_000);
    check_val("rst_score", 32'({score_count1, score_count0}), 0);

    // start -> choose level 3 -> idle -> play
    tick(1, 1, 0, 3'b000, 4'b0000, 0, 0);
    check_val("to_choose", 32'(game_state), 1);
    tick(1, 0, 0, 3'b100, 4'b0000, 0, 0);
    check_val("to_idle", 32'(game_state), 2);
    check_val("lvl3", 32'(level), 3);
    check_val("spd3", 32'(mov_speed), 6_250_000);
    tick(1, 1, 0, 3'b000, 4'b0000, 0, 0);
    check_val("to_play", 32'(game_state), 3);

    // direction: LEFT reverses RIGHT, UP accepted, DOWN reverses UP
    tick(1, 0, 0, 3'b000, 4'b0010, 0, 0);
    check_val("dir_left_rej", 32'(dir_state), 3);
    tick(1, 0, 0, 3'b000, 4'b0001, 0, 0);
    check_val("dir_up", 32'(dir_state), 0);
    tick(1, 0, 0, 3'b000, 4'b0100, 0, 0);
    check_val("dir_down_rej", 32'(dir_state), 0);

    // 20 targets -> win
    for (int k = 1; k <= 20; k++) begin
      eat_pulse();
      if (k == 9)  check_val("score09", 32'({score_count1, score_count0}), 32'h09);
      if (k == 10) check_val("score10", 32'({score_count1, score_count0}), 32'h10);
    end
    check_val("score20", 32'({score_count1, score_count0}), 32'h20);
    check_val("win", 32'(game_state), 5);

    // back through start, level 1
    tick(1, 1, 0, 3'b000, 4'b0000, 0, 0);
    check_val("win_exit", 32'(game_state), 0);
    tick(1, 1, 0, 3'b000, 4'b0000, 0, 0);
    tick(1, 0, 0, 3'b001, 4'b0000, 0, 0);
    check_val("lvl1", 32'(level), 1);
    check_val("idle_score", 32'({score_count1, score_count0}), 0);
    tick(1, 1, 0, 3'b000, 4'b0000, 0, 0);
    for (int k = 0; k < 10; k++) eat_pulse();
`ifdef SNAKE_SCORE_SPEEDUP_EN
    check_val("speedup", 32'(mov_speed), 24_000_000);
`else
    check_val("speed_const", 32'(mov_speed), 25_000_000);
`endif

    // pause freezes score
    tick(1, 0, 1, 3'b000, 4'b0000, 0, 0);
    check_val("paused", 32'(game_state), 4);
    eat_pulse();
    check_val("pause_score", 32'({score_count1, score_count0}), 32'h10);
    tick(1, 0, 1, 3'b000, 4'b0000, 0, 0);
    check_val("resumed", 32'(game_state), 3);

    // lost beats pause; over hold of 8 cycles
    tick(1, 0, 1, 3'b000, 4'b0000, 0, 1);
    check_val("over", 32'(game_state), 6);
    for (int k = 0; k < 7; k++) tick(1, 0, 0, 3'b000, 4'b0000, 0, 0);
    check_val("over_hold", 32'(game_state), 6);
    tick(1, 0, 0, 3'b000, 4'b0000, 0, 0);
    check_val("over_exit", 32'(game_state), 0);

    // random phase
    verbose = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      bit rs, st, pa, at, lo;
      bit [2:0] lv;
      bit [3:0] kd;
      rs = ($urandom_range(0, 299) != 0);
      st = ($urandom_range(0, 5) == 0);
      pa = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      kd = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      at = ($urandom_range(0, 2) == 0);
      lo = ($urandom_range(0, 299) == 0);
      tick(rs, st, pa, lv, kd, at, lo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
